// File: rtl/wildcard_priority_matcher.sv
// wildcard_priority_matcher
//   Classifies a valid/ready stream of WIDTH-bit words against a runtime
//   programmable table of NUM_PAT value/care patterns. The lowest-index
//   enabled matching entry wins. Each result is held in a one-deep output
//   register, and saturating hit/miss statistics are kept.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   cfg_we/idx/value/care/en    table entry write (idx >= NUM_PAT ignored)
//   in_valid/in_ready/in_data   input beat handshake and data
//   out_valid/out_ready         result handshake
//   out_hit/out_idx/out_multi   result fields: any match, lowest matching
//                               index (0 on miss), two or more matches
//   cnt_clr                     synchronous counter clear, beats increment
//   hit_cnt/miss_cnt            saturating statistics

// One table entry: its stored pattern plus the match compare.
module wildcard_priority_matcher_entry #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] wr_value,
  input  logic [WIDTH-1:0] wr_care,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data,
  output logic             match
);
  logic [WIDTH-1:0] value, care;
  logic             en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      care  <= '0;
      en    <= 1'b0;
    end else if (we) begin
      value <= wr_value;
      care  <= wr_care;
      en    <= wr_en;
    end
  end

  // Wildcards come only from care; the compare is strictly 2-state.
  assign match = en && (((data ^ value) & care) == '0);
endmodule

module wildcard_priority_matcher #(
  parameter int WIDTH   = 4,
  parameter int NUM_PAT = 4,
  parameter int IDX_W   = $clog2(NUM_PAT),
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic [WIDTH-1:0] cfg_care,
  input  logic             cfg_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_multi,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             multi;
  } res_t;

  logic [NUM_PAT-1:0] match;
  res_t               res_n, res_q;
  logic               acc;

  // The table is compared combinationally against in_data, so a beat
  // accepted on the same edge as a cfg write still sees the old entry.
  for (genvar i = 0; i < NUM_PAT; i++) begin : g_ent
    localparam logic [IDX_W-1:0] ID = IDX_W'(i);
    wildcard_priority_matcher_entry #(.WIDTH(WIDTH)) u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (cfg_we && (cfg_idx == ID)),
      .wr_value (cfg_value),
      .wr_care  (cfg_care),
      .wr_en    (cfg_en),
      .data     (in_data),
      .match    (match[i])
    );
  end

  // Priority encode: first match sets hit/idx, any later match flags overlap.
  always_comb begin
    res_n = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      if (match[i]) begin
        if (!res_n.hit) begin
          res_n.hit = 1'b1;
          res_n.idx = IDX_W'(i);
        end else begin
          res_n.multi = 1'b1;
        end
      end
    end
  end

  // A draining result frees the register in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      res_q     <= res_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_hit   = res_q.hit;
  assign out_idx   = res_q.idx;
  assign out_multi = res_q.multi;

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (acc) begin
      if (res_n.hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wildcard_priority_matcher.sv
module tb_wildcard_priority_matcher;
  localparam int WIDTH = 4, NP = 3, IW = 2, CW = 2;

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] idx;
    logic          multi;
  } res_t;

  logic clk, rst_n;
  logic cfg_we, cfg_en, in_valid, in_ready, out_valid, out_ready;
  logic out_hit, out_multi, cnt_clr;
  logic [IW-1:0] cfg_idx, out_idx;
  logic [WIDTH-1:0] cfg_value, cfg_care, in_data;
  logic [CW-1:0] hit_cnt, miss_cnt;

  wildcard_priority_matcher #(.WIDTH(WIDTH), .NUM_PAT(NP), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value), .cfg_care(cfg_care), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hit(out_hit), .out_idx(out_idx), .out_multi(out_multi),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: table, counters, result scoreboard.
  logic [WIDTH-1:0] m_val [NP];
  logic [WIDTH-1:0] m_care[NP];
  logic             m_en  [NP];
  int               m_hit, m_miss;
  res_t             q[$];

  function automatic res_t model(input logic [WIDTH-1:0] d);
    res_t r;
    int   n;
    r = '0;
    n = 0;
    for (int i = NP - 1; i >= 0; i--)
      if (m_en[i] && (((d ^ m_val[i]) & m_care[i]) == '0)) begin
        r.hit = 1'b1;
        r.idx = IW'(i);
        n++;
      end
    r.multi = (n >= 2);
    return r;
  endfunction

  // Sample mid-cycle; inputs change just after the rising edge.
  always @(negedge clk) begin
    bit acc;
    if (!rst_n) begin
      q.delete();
      m_hit = 0;
      m_miss = 0;
      for (int i = 0; i < NP; i++) begin
        m_val[i] = '0; m_care[i] = '0; m_en[i] = 1'b0;
      end
    end else begin
      chk("hit_cnt", 32'(hit_cnt), 32'(m_hit));
      chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
      if (out_valid && q.size() != 0) begin
        chk("out_hit", 32'(out_hit), 32'(q[0].hit));
        chk("out_idx", 32'(out_idx), 32'(q[0].idx));
        chk("out_multi", 32'(out_multi), 32'(q[0].multi));
      end
      acc = in_valid && (q.size() == 0 || out_ready);
      if (out_ready && q.size() != 0) void'(q.pop_front());
      if (acc) q.push_back(model(in_data));
      if (cnt_clr) begin
        m_hit = 0; m_miss = 0;
      end else if (acc) begin
        if (model(in_data).hit) begin
          if (m_hit < 3) m_hit++;
        end else if (m_miss < 3) m_miss++;
      end
      if (cfg_we && cfg_idx < IW'(NP)) begin
        m_val[cfg_idx] = cfg_value; m_care[cfg_idx] = cfg_care; m_en[cfg_idx] = cfg_en;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input logic [3:0] v, input logic [3:0] c, input logic e);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_value = v; cfg_care = c; cfg_en = e;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 0; cfg_idx = 0; cfg_value = 0; cfg_care = 0; cfg_en = 0;
    in_valid = 0; in_data = 0; out_ready = 1; cnt_clr = 0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_fields", {out_hit, out_idx, out_multi}, 0);
    chk("rst_cnts", {hit_cnt, miss_cnt}, 0);
    step();
    rst_n = 1'b1;
    step();

    cfg(0, 4'b1000, 4'b1010, 1);
    cfg(1, 4'b1000, 4'b1100, 1);
    cfg(2, 4'b0100, 4'b0100, 1);
    cfg(3, 4'b0000, 4'b0000, 1);  // out of range: must not create a catch-all

    // Overlap priority and miss
    send(4'b1000);
    chk("ovl_p0", {out_valid, out_hit, out_idx, out_multi}, {1'b1, 1'b1, 2'd0, 1'b1});
    send(4'b1010);
    chk("p1", {out_hit, out_idx, out_multi}, {1'b1, 2'd1, 1'b0});
    send(4'b0110);
    chk("p2", {out_hit, out_idx, out_multi}, {1'b1, 2'd2, 1'b0});
    send(4'b0010);
    chk("miss", {out_hit, out_idx}, {1'b0, 2'd0});
    chk("cnt_3hit", 32'(hit_cnt), 3);
    chk("cnt_1miss", 32'(miss_cnt), 1);

    // Clear with a simultaneous accept
    cnt_clr = 1'b1;
    send(4'b1000);
    cnt_clr = 1'b0;
    chk("clr_cnts", {hit_cnt, miss_cnt}, 0);
    step();

    // Backpressure
    out_ready = 1'b0;
    send(4'b1010);
    in_valid = 1'b1; in_data = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_hold", {out_valid, out_hit, out_idx, out_multi}, {1'b1, 1'b1, 2'd1, 1'b0});
      chk("bp_cnt", 32'(hit_cnt), 1);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("drain_accept", {out_valid, out_idx}, {1'b1, 2'd2});
    chk("drain_cnt", 32'(hit_cnt), 2);
    step();

    // Reconfig race: disable P0 while 1000 is accepted
    cfg_we = 1'b1; cfg_idx = 0; cfg_value = 4'b1000; cfg_care = 4'b1010; cfg_en = 1'b0;
    in_valid = 1'b1; in_data = 4'b1000;
    step();
    cfg_we = 1'b0;
    chk("race_old", {out_idx, out_multi}, {2'd0, 1'b1});
    step();
    in_valid = 1'b0;
    chk("race_new", {out_hit, out_idx, out_multi}, {1'b1, 2'd1, 1'b0});

    // Saturation
    for (int i = 0; i < 5; i++) send(4'b1010);
    chk("sat", 32'(hit_cnt), 3);

    // Reset mid-stream
    in_valid = 1'b1; in_data = 4'b0110; out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_cnts", {hit_cnt, miss_cnt}, 0);
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    send(4'b1000);
    chk("post_rst_miss", {out_valid, out_hit}, {1'b1, 1'b0});
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
